// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared types and helpers for the round-robin multiplier scheduler.
// Rev 1.0
`default_nettype none

package mult_sched_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } sched_state_e;

  localparam int PERF_CNT_W = 16;

  // Requester ID width; a single requester still needs one bit of tag.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_rr_scheduler_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from rr_ptr_i.
// Rev 1.0
`default_nettype none

module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     grant_id_o
);

  always_comb begin
    int   idx;
    logic found;
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap keeps non-power-of-two NUM_REQ inside the valid range.
      idx = int'(rr_ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (enable_i && !found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = IDW'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin sharing of one pipelined multiplier with halt/drain.
// Optional per-requester perf counters under MULT_SCHED_PERF_EN. Rev 1.0
`default_nettype none

module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int DATAWIDTH    = 4,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0]    req_a,
  input  logic [NUM_REQ*DATAWIDTH-1:0]    req_b,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [2*DATAWIDTH-1:0]          rsp_z,
  input  logic                            halt_req,
  output logic                            halted,
  output logic                            busy,
  output logic                            err_orphan,
  output logic                            mult_i_valid,
  output logic [DATAWIDTH-1:0]            mult_a,
  output logic [DATAWIDTH-1:0]            mult_b,
  input  logic                            mult_o_valid,
  input  logic [2*DATAWIDTH-1:0]          mult_z,
  output logic [NUM_REQ*PERF_CNT_W-1:0]   perf_grant_cnt,
  output logic [NUM_REQ*PERF_CNT_W-1:0]   perf_stall_cnt
);

  localparam int IDW = id_width(NUM_REQ);

  sched_state_e             state_q;
  logic                     halted_q;
  logic [IDW-1:0]           rr_ptr_q;
  logic                     mult_valid_q;
  logic [DATAWIDTH-1:0]     mult_a_q, mult_b_q;
  logic [IDW-1:0]           issue_id_q;
  logic [MULT_LATENCY-1:0]  tag_valid_q;
  logic [IDW-1:0]           tag_id_q [MULT_LATENCY];
  logic                     err_q;

  logic                     arb_en;
  logic [NUM_REQ-1:0]       grant;
  logic [IDW-1:0]           grant_id;
  logic                     xfer;

  assign arb_en = (state_q == RUN) && !halt_req && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req_i      (req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .enable_i   (arb_en),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign req_ready = grant;
  assign xfer      = |(grant & req_valid);
  assign busy      = mult_valid_q | (|tag_valid_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      mult_valid_q <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      issue_id_q   <= '0;
      tag_valid_q  <= '0;
      for (int s = 0; s < MULT_LATENCY; s++) tag_id_q[s] <= '0;
      err_q        <= 1'b0;
    end else begin
      mult_valid_q <= xfer;
      if (xfer) begin
        mult_a_q   <= req_a[int'(grant_id)*DATAWIDTH +: DATAWIDTH];
        mult_b_q   <= req_b[int'(grant_id)*DATAWIDTH +: DATAWIDTH];
        issue_id_q <= grant_id;
        rr_ptr_q   <= (int'(grant_id) == NUM_REQ-1) ? '0 : grant_id + 1'b1;
      end else begin
        mult_a_q   <= '0;
        mult_b_q   <= '0;
      end
      // Tag stage 0 follows the issue register; the last stage meets mult_o_valid.
      tag_valid_q[0] <= mult_valid_q;
      tag_id_q[0]    <= issue_id_q;
      for (int s = 1; s < MULT_LATENCY; s++) begin
        tag_valid_q[s] <= tag_valid_q[s-1];
        tag_id_q[s]    <= tag_id_q[s-1];
      end
      if (mult_o_valid != tag_valid_q[MULT_LATENCY-1]) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (halt_req) state_q <= DRAIN;
        DRAIN: begin
          if (!busy) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (!halt_req) begin
            state_q  <= RUN;
          end
        end
        HALTED: if (!halt_req) begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (mult_o_valid && tag_valid_q[MULT_LATENCY-1])
      rsp_valid[tag_id_q[MULT_LATENCY-1]] = 1'b1;
  end

  assign rsp_z        = mult_z;
  assign halted       = halted_q;
  assign err_orphan   = err_q;
  assign mult_i_valid = mult_valid_q;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;

`ifdef MULT_SCHED_PERF_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    logic [PERF_CNT_W-1:0] grant_cnt_q, stall_cnt_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        grant_cnt_q <= '0;
        stall_cnt_q <= '0;
      end else begin
        if (req_valid[g] && req_ready[g] && (grant_cnt_q != '1))
          grant_cnt_q <= grant_cnt_q + 1'b1;
        if (req_valid[g] && !req_ready[g] && (stall_cnt_q != '1))
          stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
    assign perf_grant_cnt[g*PERF_CNT_W +: PERF_CNT_W] = grant_cnt_q;
    assign perf_stall_cnt[g*PERF_CNT_W +: PERF_CNT_W] = stall_cnt_q;
  end
`else
  assign perf_grant_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: directed vectors with a response scoreboard and a 2-stage multiplier model.
// Rev 1.0
`default_nettype none

module tb_mult_rr_scheduler;

  localparam int DW = 4;
  localparam int NR = 4;
  localparam int ML = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [NR-1:0]     rsp_valid;
  logic [2*DW-1:0]   rsp_z;
  logic              halt_req, halted, busy, err_orphan;
  logic              mult_i_valid;
  logic [DW-1:0]     mult_a, mult_b;
  logic              mult_o_valid;
  logic [2*DW-1:0]   mult_z;
  logic [NR*16-1:0]  perf_grant_cnt, perf_stall_cnt;

  // Behavioural stand-in for the pipelined multiplier, two stages, shared reset.
  logic              m_v1, m_v2, force_ov;
  logic [2*DW-1:0]   m_p1, m_p2;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_v1 <= 1'b0; m_v2 <= 1'b0; m_p1 <= '0; m_p2 <= '0;
    end else begin
      m_v1 <= mult_i_valid; m_p1 <= mult_a * mult_b;
      m_v2 <= m_v1;         m_p2 <= m_p1;
    end
  end
  assign mult_o_valid = m_v2 | force_ov;
  assign mult_z       = m_p2;

  mult_rr_scheduler #(.DATAWIDTH(DW), .NUM_REQ(NR), .MULT_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_z(rsp_z),
    .halt_req(halt_req), .halted(halted), .busy(busy), .err_orphan(err_orphan),
    .mult_i_valid(mult_i_valid), .mult_a(mult_a), .mult_b(mult_b),
    .mult_o_valid(mult_o_valid), .mult_z(mult_z),
    .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  typedef struct { int id; int z; } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push(input int id, input int z);
    exp_t e;
    e.id = id; e.z = z;
    sb.push_back(e);
  endtask

  // Monitor: every response strobe is matched against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_route", 64'(rsp_valid), 64'(4'b0001 << e.id));
          chk("rsp_z", 64'(rsp_z), 64'(e.z));
        end
      end
    end
  end

  int to;
  // Hand-computed products for requesters 0..3: 2*3, 4*5, 7*9, 15*15.
  int prod [4] = '{6, 20, 63, 225};

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; halt_req = 1'b0; force_ov = 1'b0;
    tick(); tick();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_mvalid", 64'(mult_i_valid), 64'd0);
    chk("rst_mab", 64'({mult_a, mult_b}), 64'd0);
    chk("rst_flags", 64'({rsp_valid, halted, busy, err_orphan}), 64'd0);
    chk("rst_perf", 64'(|{perf_grant_cnt, perf_stall_cnt}), 64'd0);
    rst = 1'b0;
    tick();

    // Single request on requester 2: 3*5 = 15, response three cycles later.
    req_valid = 4'b0100; req_a[11:8] = 4'd3; req_b[11:8] = 4'd5;
    #1 chk("t1_ready", 64'(req_ready), 64'b0100);
    push(2, 15);
    tick(); req_valid = '0;
    #1 chk("t1_issue", 64'({mult_i_valid, mult_a, mult_b}), 64'({1'b1, 4'd3, 4'd5}));
    tick();
    #1 chk("t1_not_yet", 64'(rsp_valid), 64'd0);
    tick();
    #1 chk("t1_rsp", 64'({rsp_valid, rsp_z}), 64'({4'b0100, 8'd15}));
    tick(); tick();

    // All four requesters valid from reset: strict rotation 0,1,2,3,0,1,2,3.
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = {4'd15, 4'd7, 4'd4, 4'd2};
    req_b = {4'd15, 4'd9, 4'd5, 4'd3};
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_rotation", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      push(k % 4, prod[k % 4]);
      tick();
    end
    req_valid = '0;
`ifdef MULT_SCHED_PERF_EN
    chk("t2_grant_cnt3", 64'(perf_grant_cnt[63:48]), 64'd2);
    chk("t2_stall_cnt0", 64'(perf_stall_cnt[15:0]), 64'd6);
`else
    chk("t2_perf_tied", 64'(|{perf_grant_cnt, perf_stall_cnt}), 64'd0);
`endif
    for (int k = 0; k < 5; k++) tick();

    // Halt with two ops in flight; ops drain, then grants resume at rr_ptr.
    req_valid = 4'b0010;
    #1 chk("t3_grant_a", 64'(req_ready), 64'b0010);
    push(1, 20);
    tick(); req_valid = 4'b0100;
    #1 chk("t3_grant_b", 64'(req_ready), 64'b0100);
    push(2, 63);
    tick(); req_valid = 4'b1111; halt_req = 1'b1;
    #1 chk("t3_halt_nogrant", 64'(req_ready), 64'd0);
    to = 0;
    while (busy && to < 12) begin
      chk("t3_drain_ready", 64'(req_ready), 64'd0);
      chk("t3_drain_halted", 64'(halted), 64'd0);
      tick(); #1; to++;
    end
    chk("t3_drain_bound", 64'(busy), 64'd0);
    chk("t3_halted_lag", 64'(halted), 64'd0);
    tick();
    #1 chk("t3_halted", 64'({halted, req_ready}), 64'({1'b1, 4'b0000}));
    tick(); halt_req = 1'b0;
    #1 chk("t3_release_nogrant", 64'(req_ready), 64'd0);
    tick();
    #1 chk("t3_resume_ptr", 64'({halted, req_ready}), 64'({1'b0, 4'b1000}));
    push(3, 225);
    tick(); req_valid = '0;
    for (int k = 0; k < 5; k++) tick();

    // Reset one cycle after a grant: the op is dropped.
    req_valid = 4'b0001;
    #1 chk("t4_grant", 64'(req_ready), 64'b0001);
    tick(); req_valid = '0; rst = 1'b1;
    tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t4_no_rsp", 64'({rsp_valid, mult_i_valid, busy, halted, err_orphan}), 64'd0);
      tick();
    end

    // Result strobe with nothing in flight sets the sticky orphan flag.
    force_ov = 1'b1;
    #1 chk("t5_no_route", 64'(rsp_valid), 64'd0);
    tick(); force_ov = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t5_err_sticky", 64'(err_orphan), 64'd1);
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    #1 chk("t5_err_cleared", 64'(err_orphan), 64'd0);
    tick(); tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
Shares one pipelined array_multiplier instance among NUM_REQ requesters using round-robin arbitration. Registers the granted operands into the multiplier and tracks each in-flight operation's requester ID in a tag pipeline aligned to the multiplier latency. Routes each product back to its owner. Provides a halt/drain handshake so software or a retiming harness can quiesce the datapath.

Parameters:
DATAWIDTH, 4, operand width; must match the attached multiplier.
NUM_REQ, 4, number of requesters (2..16).
MULT_LATENCY, 2, cycles from mult_i_valid to mult_o_valid; must equal the number of enabled pipeline stages in the attached multiplier.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
req_a  in  NUM_REQ*DATAWIDTH  packed operand A; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH]
req_b  in  NUM_REQ*DATAWIDTH  packed operand B; same packing as req_a
rsp_valid  out  NUM_REQ  one-hot, single-cycle result strobe; no backpressure
rsp_z  out  2*DATAWIDTH  product, valid with rsp_valid
halt_req  in  1  request to stop issuing and drain
halted  out  1  no ops in flight, no grants
busy  out  1  any op in flight
err_orphan  out  1  sticky tag/result mismatch flag
mult_i_valid  out  1  to multiplier i_valid
mult_a, mult_b  out  DATAWIDTH  to multiplier A and B
mult_o_valid  in  1  from multiplier o_valid
mult_z  in  2*DATAWIDTH  from multiplier Z_final

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. Tie the multiplier to the same clk and rst.
- Reset values: req_ready=0, mult_i_valid=0, mult_a=0, mult_b=0, rsp_valid=0, halted=0, busy=0, err_orphan=0, rr_ptr=0, all tags invalid, state=RUN.
- Arbitration (combinational):
  - Only in RUN with halt_req=0.
  - Grant the first requester with req_valid=1, searching upward from rr_ptr with wrap modulo NUM_REQ.
  - req_ready is high only for the grantee.
  - A transfer occurs when req_valid & req_ready. On a transfer, rr_ptr <= grantee+1 (wraps to 0).
  - With no transfer, rr_ptr holds.
- Issue (registered):
  - Cycle after a transfer: mult_i_valid=1 and mult_a/mult_b carry the grantee's operands.
  - Otherwise mult_i_valid=0 and mult_a/mult_b=0.
  - Throughput: one op per cycle.
- Tag pipeline:
  - MULT_LATENCY entries of {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 captures {mult_i_valid, issued id}; entries shift every cycle.
  - The last stage aligns with mult_o_valid.
- Response:
  - rsp_valid[id] = mult_o_valid & tag_valid; rsp_z = mult_z.
  - Latency from request handshake to rsp_valid is exactly 1+MULT_LATENCY cycles.
- err_orphan: set when mult_o_valid != last tag valid. Cleared only by rst.
- busy = mult_i_valid | OR of all tag valid bits.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when halt_req=1. No grant in that cycle.
  - DRAIN -> HALTED when busy=0.
  - DRAIN -> RUN if halt_req drops before busy clears.
  - HALTED -> RUN when halt_req=0.
  - halted=1 only in HALTED.
  - In-flight ops always complete and respond during DRAIN.
- Simultaneous events:
  - halt_req rising in the same cycle as req_valid: no grant.
  - Reset mid-operation: all tags dropped, no rsp_valid after reset, the multiplier is flushed by the shared rst.
- Widths:
  - Product is the full 2*DATAWIDTH bits, unsigned; no truncation.
  - rr_ptr is $clog2(NUM_REQ) bits; non-power-of-two NUM_REQ wraps explicitly at NUM_REQ-1.

Optional Feature:
MULT_SCHED_PERF_EN:
- Defined: adds per-requester 16-bit saturating counters.
  - grant_cnt increments on each transfer.
  - stall_cnt increments when req_valid=1 and req_ready=0.
  - Both reset to 0 and are exposed on outputs perf_grant_cnt and perf_stall_cnt (NUM_REQ*16 each).
- Undefined: both ports exist but are tied to 0; no counter flops are synthesized.

Decomposition:
- Package mult_sched_pkg: sched_state_e enum {RUN, DRAIN, HALTED}, localparam PERF_CNT_W=16, function id_width(n) returning $clog2(n) with a minimum of 1.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, rr_ptr, enable; outputs one-hot grant and encoded grant id.

Test Plan:
- DATAWIDTH=4, MULT_LATENCY=2: req_valid[2]=1, a=3, b=5 at cycle T -> req_ready[2]=1 at T; mult_i_valid at T+1; rsp_valid=4'b0100, rsp_z=8'd15 at T+3.
- All four requesters held valid for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; one transfer per cycle. Operand 15*15 on requester 3 -> rsp_z=8'd225 routed only to requester 3.
- halt_req asserted with 2 ops in flight -> no further req_ready; both responses delivered; halted=1 exactly the cycle after busy=0. Deassert -> grants resume at rr_ptr.
- rst asserted one cycle after a grant -> no rsp_valid in following cycles; all outputs at reset values; err_orphan=0.
- Force mult_o_valid=1 with no tags in flight -> err_orphan=1, stays set until rst.
- With MULT_SCHED_PERF_EN: requester 1 valid for 10 cycles while requester 0 monopolises alternating slots -> grant_cnt[1]=5, stall_cnt[1]=5. Counters saturate at 16'hFFFF.
